// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: next-PC and StallF generation for the fetch-stage PC
// register. It selects between the reset vector, PCF+4 and a Decode-stage
// branch/jump redirect, and runs the instruction-memory wait-state handshake.
// A redirect that arrives while imem is stalling is held until the fetch
// completes.
// Optional feature: define FETCH_TIMEOUT_EN to build the wait-cycle counter
// and the sticky fetch_timeout flag. Without it, fetch_timeout is tied low.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0040_0030,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned WAITCNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    input  logic        StallHaz,
    input  logic        BranchTakenD,
    input  logic [31:0] BranchTargetD,
    input  logic        JumpD,
    input  logic [31:0] JumpTargetD,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] PC,
    output logic        StallF,
    output logic        FlushD,
    output logic        InstrValidF,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    logic        redir;
    logic [31:0] live_tgt;

    // Targets are always word aligned, so the two low bits are never consumed.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^{BranchTargetD[1:0], JumpTargetD[1:0]};

    // Qualify the Decode redirect: ignored under a hazard stall, branch beats jump.
    always_comb begin
        redir    = (BranchTakenD | JumpD) & ~StallHaz;
        live_tgt = BranchTakenD ? {BranchTargetD[31:2], 2'b00}
                                : {JumpTargetD[31:2], 2'b00};
    end

    // Next-state and output decode for the fetch sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        state_d     = state_q;
        pending_d   = pending_q;
        redir_tgt_d = redir_tgt_q;
        imem_req    = 1'b1;
        PC          = PCF;
        StallF      = 1'b0;
        FlushD      = 1'b0;
        InstrValidF = 1'b0;

        case (state_q)
            BOOT: begin
                imem_req = 1'b0;
                PC       = RESET_VECTOR;
                state_d  = RUN;
            end
            RUN, WAIT: begin
                if (!imem_ready) begin
                    // Hold the PC register; remember the newest redirect seen while waiting.
                    StallF  = 1'b1;
                    state_d = WAIT;
                    if (redir) begin
                        pending_d   = 1'b1;
                        redir_tgt_d = live_tgt;
                    end
                end else begin
                    state_d = RUN;
                    if (redir) begin
                        // A live redirect supersedes anything still pending.
                        PC        = live_tgt;
                        FlushD    = 1'b1;
                        pending_d = 1'b0;
                    end else if (state_q == WAIT && pending_q) begin
                        PC        = redir_tgt_q;
                        FlushD    = 1'b1;
                        pending_d = 1'b0;
                    end else if (StallHaz) begin
                        StallF = 1'b1;
                    end else begin
                        PC          = PCF + 32'd4;
                        InstrValidF = 1'b1;
                    end
                end
            end
            default: begin
                imem_req = 1'b0;
                PC       = RESET_VECTOR;
                state_d  = BOOT;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the held target is reset too so a stale value can never leak out after reset.
            state_q     <= BOOT;
            pending_q   <= 1'b0;
            redir_tgt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state_q     <= state_d;
            pending_q   <= pending_d;
            redir_tgt_q <= redir_tgt_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [WAITCNT_W-1:0] wait_cnt_q;
    logic                 timeout_q;
    logic                 timeout_hit;
    logic                 counting;

    // The flag rises during the wait cycle that reaches the limit, then sticks.
    assign counting      = (state_q == WAIT) && !imem_ready;
    assign timeout_hit   = counting && (wait_cnt_q == WAITCNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_timeout = timeout_q | timeout_hit;

    // Saturating count of WAIT cycles, cleared whenever the fetch is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (counting) begin
                if (wait_cnt_q != '1) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    // Without the timeout feature the configuration is only carried, never used.
    logic [WAITCNT_W-1:0] unused_wait_cfg;
    assign unused_wait_cfg = WAITCNT_W'(TIMEOUT_CYCLES);
    assign fetch_timeout   = 1'b0;
`endif

endmodule
